// File: rtl/noncoh_acc_ctrl.sv
// Noncoherent accumulation buffer controller: per-bin read / saturating write-back,
// per-round extra_shift scaling and last-round peak search.
module noncoh_acc_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          round_start,
  input  logic          first_round,
  input  logic          last_round,
  input  logic [3:0]    noncoh_shift_cfg,
  input  logic          coh_valid,
  input  logic [8:0]    noncoh_out,
  input  logic          exceed,
  output logic [7:0]    noncoh_data,
  output logic [3:0]    noncoh_shift,
  output logic          extra_shift,
  output logic [3:0]    scale_cnt,
  output logic          busy,
  output logic          overrun,
  output logic          peak_valid,
  output logic [8:0]    peak_value,
  output logic [AW-1:0] peak_index
);
  localparam int            NSTG      = 3;
  localparam logic [AW:0]   LAST_BIN  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   BIN_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW:0]     bin_reg;
  logic            round_active_reg;
  logic            first_reg;
  logic            last_reg;
  logic            exceed_seen_reg;
  logic [NSTG-1:0] vld_reg;
  logic [AW-1:0]   addr_reg [NSTG];
  logic [7:0]      mem [DEPTH];
  logic [7:0]      rd_data_reg;

  logic            accept;
  logic            start_ok;
  logic            wr_en;
  logic            peak_upd;
  logic [7:0]      wr_data;

  assign busy     = round_active_reg | (|vld_reg);
  assign accept   = coh_valid & round_active_reg & (bin_reg <= LAST_BIN);
  assign start_ok = round_start & ~busy;
  assign wr_en    = vld_reg[NSTG-1];
  assign wr_data  = noncoh_out[8] ? 8'hFF : noncoh_out[7:0];
  assign peak_upd = wr_en & last_reg & (noncoh_out > peak_value);

  // Buffer RAM: registered read at issue, write-back three cycles later.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data_reg <= mem[bin_reg[AW-1:0]];
    end
    if (wr_en) begin
      mem[addr_reg[NSTG-1]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_reg <= '0;
      for (int i = 0; i < NSTG; i++) begin
        addr_reg[i] <= '0;
      end
    end else begin
      vld_reg     <= {vld_reg[NSTG-2:0], accept};
      addr_reg[0] <= bin_reg[AW-1:0];
      for (int i = 1; i < NSTG; i++) begin
        addr_reg[i] <= addr_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bin_reg          <= '0;
      round_active_reg <= 1'b0;
      first_reg        <= 1'b0;
      last_reg         <= 1'b0;
      exceed_seen_reg  <= 1'b0;
      noncoh_data      <= '0;
      noncoh_shift     <= '0;
      extra_shift      <= 1'b0;
      scale_cnt        <= '0;
      overrun          <= 1'b0;
      peak_valid       <= 1'b0;
      peak_value       <= '0;
      peak_index       <= '0;
    end else begin
      peak_valid <= wr_en & last_reg & (addr_reg[NSTG-1] == LAST_ADDR);

      if (accept) begin
        bin_reg <= bin_reg + BIN_ONE;
        if (bin_reg == LAST_BIN) begin
          round_active_reg <= 1'b0;
        end
      end else if (coh_valid) begin
        overrun <= 1'b1;
      end

      if (vld_reg[0]) begin
        noncoh_data <= first_reg ? 8'd0 : rd_data_reg;
      end

      if (vld_reg[1] && exceed) begin
        exceed_seen_reg <= 1'b1;
      end

      if (peak_upd) begin
        peak_value <= noncoh_out;
        peak_index <= addr_reg[NSTG-1];
      end

      // A start is only taken when idle, so none of the pipeline updates above can collide.
      if (start_ok) begin
        first_reg        <= first_round;
        last_reg         <= last_round;
        noncoh_shift     <= noncoh_shift_cfg;
        extra_shift      <= exceed_seen_reg;
        exceed_seen_reg  <= 1'b0;
        bin_reg          <= '0;
        round_active_reg <= 1'b1;
        if (exceed_seen_reg && (scale_cnt != 4'hF)) begin
          scale_cnt <= scale_cnt + 4'd1;
        end
        if (last_round) begin
          peak_value <= '0;
          peak_index <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_noncoh_acc_ctrl.sv
// Randomized bench for noncoh_acc_ctrl: transaction-level reference model checked every cycle,
// plus hand-computed expectations for saturation, scaling, peak search, overrun and reset.
module tb_noncoh_acc_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          round_start = 1'b0;
  logic          first_round = 1'b0;
  logic          last_round = 1'b0;
  logic [3:0]    noncoh_shift_cfg = '0;
  logic          coh_valid = 1'b0;
  logic [8:0]    noncoh_out = '0;
  logic          exceed = 1'b0;
  logic [7:0]    noncoh_data;
  logic [3:0]    noncoh_shift;
  logic          extra_shift;
  logic [3:0]    scale_cnt;
  logic          busy;
  logic          overrun;
  logic          peak_valid;
  logic [8:0]    peak_value;
  logic [AW-1:0] peak_index;

  always #5 clk = ~clk;

  noncoh_acc_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_b(rst_b), .round_start(round_start), .first_round(first_round),
    .last_round(last_round), .noncoh_shift_cfg(noncoh_shift_cfg), .coh_valid(coh_valid),
    .noncoh_out(noncoh_out), .exceed(exceed), .noncoh_data(noncoh_data),
    .noncoh_shift(noncoh_shift), .extra_shift(extra_shift), .scale_cnt(scale_cnt),
    .busy(busy), .overrun(overrun), .peak_valid(peak_valid), .peak_value(peak_value),
    .peak_index(peak_index)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: each accepted result is a timestamped entry; outputs follow from its age.
  typedef struct { int issue; int bin; } pend_t;
  pend_t q[$];
  int m_mem [DEPTH];
  int m_bin, m_shift, m_scale, m_data, m_pv, m_pi;
  bit m_active, m_first, m_last, m_extra, m_exseen, m_overrun, m_pvalid, m_known;

  bit slot_ex [8];
  bit slot_ex_v [8];
  int slot_out [8];
  bit slot_out_v [8];
  int probe_at = -1;
  int probe_exp = 0;
  int pv_count = 0;
  int val [DEPTH+1];

  function automatic void m_reset();
    q.delete();
    m_bin = 0; m_shift = 0; m_scale = 0; m_data = 0; m_pv = 0; m_pi = 0;
    m_active = 0; m_first = 0; m_last = 0; m_extra = 0; m_exseen = 0;
    m_overrun = 0; m_pvalid = 0; m_known = 1;
  endfunction

  function automatic void model_step();
    bit busy_pre, act_pre;
    int age, b, o;
    if (!rst_b) begin
      m_reset();
      return;
    end
    cyc++;
    busy_pre = m_active || (q.size() != 0);
    act_pre  = m_active;
    m_pvalid = 0;
    o = int'(noncoh_out);
    foreach (q[i]) begin
      age = cyc - q[i].issue;
      b   = q[i].bin;
      if (age == 1) begin
        if (m_first) begin
          m_data = 0; m_known = 1;
        end else begin
          m_data = m_mem[b]; m_known = (m_mem[b] >= 0);
        end
      end else if (age == 2) begin
        if (exceed) m_exseen = 1;
      end else if (age == 3) begin
        m_mem[b] = (o > 255) ? 255 : o;
        if (m_last && o > m_pv) begin
          m_pv = o; m_pi = b;
        end
        if (m_last && b == DEPTH-1) m_pvalid = 1;
      end
    end
    while (q.size() != 0 && cyc - q[0].issue >= 3) void'(q.pop_front());
    if (coh_valid) begin
      if (act_pre && m_bin < DEPTH) begin
        q.push_back('{cyc, m_bin});
        m_bin++;
        if (m_bin == DEPTH) m_active = 0;
      end else begin
        m_overrun = 1;
      end
    end
    if (round_start && !busy_pre) begin
      m_extra  = m_exseen;
      m_exseen = 0;
      if (m_extra && m_scale < 15) m_scale++;
      m_first = first_round; m_last = last_round; m_shift = int'(noncoh_shift_cfg);
      m_bin = 0; m_active = 1;
      if (last_round) begin
        m_pv = 0; m_pi = 0;
      end
    end
  endfunction

  task automatic compare();
    bit ok;
    bit m_busy;
    m_busy = m_active || (q.size() != 0);
    checks++;
    ok = (noncoh_shift === 4'(m_shift)) && (extra_shift === m_extra) &&
         (scale_cnt === 4'(m_scale)) && (busy === m_busy) && (overrun === m_overrun) &&
         (peak_valid === m_pvalid) && (peak_value === 9'(m_pv)) && (peak_index === AW'(m_pi));
    if (m_known) ok = ok && (noncoh_data === 8'(m_data));
    if (!ok) begin
      errors++;
      $display("FAIL outputs cyc=%0d got data=%0d sh=%0d xs=%0b sc=%0d busy=%0b ovr=%0b pv=%0b pk=%0d@%0d want data=%0d sh=%0d xs=%0b sc=%0d busy=%0b ovr=%0b pv=%0b pk=%0d@%0d",
               cyc, noncoh_data, noncoh_shift, extra_shift, scale_cnt, busy, overrun, peak_valid,
               peak_value, peak_index, m_data, m_shift, m_extra, m_scale, m_busy, m_overrun,
               m_pvalid, m_pv, m_pi);
    end
  endtask

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One clock: advance the model, compare, then drive the next inputs.
  task automatic drive_cycle(input bit cv, input int v, input bit ex, input bit rs,
                             input bit fr, input bit lr, input int sh, input bit rstb_v);
    int s;
    @(negedge clk);
    model_step();
    compare();
    if (peak_valid === 1'b1) pv_count++;
    if (cyc == probe_at) begin
      lit("probe_data", 64'(noncoh_data), 64'(probe_exp));
      probe_at = -1;
    end
    rst_b            = rstb_v;
    coh_valid        = cv;
    round_start      = rs;
    first_round      = fr;
    last_round       = lr;
    noncoh_shift_cfg = 4'(sh);
    if (cv) begin
      slot_ex[(cyc+2)%8]    = ex;
      slot_ex_v[(cyc+2)%8]  = 1'b1;
      slot_out[(cyc+3)%8]   = v;
      slot_out_v[(cyc+3)%8] = 1'b1;
    end
    s = cyc % 8;
    exceed     = slot_ex_v[s]  ? slot_ex[s] : 1'($urandom);
    noncoh_out = slot_out_v[s] ? 9'(slot_out[s]) : 9'($urandom);
    slot_ex_v[s]  = 1'b0;
    slot_out_v[s] = 1'b0;
  endtask

  task automatic idle(input bit rstb_v);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, rstb_v);
  endtask

  task automatic run_round(input string tag, input bit fr, input bit lr, input int sh,
                           input int nbins, input int gap, input int exc_bin, input bit exc_rand,
                           input int probe_bin, input int pexp, input int mid_rs_bin);
    int last_cyc = 0;
    int n = 0;
    drive_cycle(0, 0, 0, 1, fr, lr, sh, 1);
    for (int b = 0; b < nbins; b++) begin
      for (int k = 0; k < 3 && gap > 0 && $urandom_range(99) < gap; k++) idle(1);
      if (b == mid_rs_bin) drive_cycle(0, 0, 0, 1, 1, 1, 9, 1);
      drive_cycle(1, val[b], (b == exc_bin) || (exc_rand && $urandom_range(15) == 0), 0, 0, 0, 0, 1);
      if (b == probe_bin) begin
        probe_at = cyc + 2; probe_exp = pexp;
      end
      last_cyc = cyc;
    end
    while ((m_active || q.size() != 0) && n < 16) begin
      idle(1);
      n++;
      if (nbins == DEPTH && cyc == last_cyc + 3) lit("busy_tail", 64'(busy), 64'd1);
      if (nbins == DEPTH && cyc == last_cyc + 4) lit("busy_fall", 64'(busy), 64'd0);
    end
    lit("drain", 64'(busy), 64'd0);
    idle(1);
    idle(1);
    $display("round %s: bins=%0d first=%0b last=%0b shift=%0d extra=%0b scale=%0d overrun=%0b",
             tag, nbins, fr, lr, sh, extra_shift, scale_cnt, overrun);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = -1;
    m_reset();
    #1 rst_b = 1'b0;
    repeat (3) idle(0);
    lit("reset_lo", {noncoh_data, noncoh_shift, extra_shift, scale_cnt, busy, overrun, peak_valid}, 64'd0);
    lit("reset_hi", {peak_value, peak_index}, 64'd0);
    idle(1);

    for (int b = 0; b < DEPTH; b++) val[b] = int'($urandom_range(511));
    val[3] = 9'h1FE;
    run_round("r1", 1, 0, 0, DEPTH, 0, -1, 0, 10, 0, -1);

    for (int b = 0; b < DEPTH; b++) val[b] = int'($urandom_range(511));
    run_round("r2", 0, 0, 3, DEPTH, 30, 10, 0, 3, 255, -1);
    lit("r2_shift", 64'(noncoh_shift), 64'd3);

    for (int b = 0; b < DEPTH; b++) val[b] = int'($urandom_range(511));
    run_round("r3", 0, 0, 1, DEPTH, 20, -1, 0, -1, 0, -1);
    lit("r3_extra", 64'(extra_shift), 64'd1);
    lit("r3_scale", 64'(scale_cnt), 64'd1);

    for (int b = 0; b < DEPTH; b++) val[b] = int'($urandom_range(199));
    val[5] = 100; val[7] = 200; val[40] = 200;
    pv_count = 0;
    run_round("r4", 0, 1, 0, DEPTH, 25, -1, 0, -1, 0, -1);
    lit("r4_extra", 64'(extra_shift), 64'd0);
    lit("r4_scale", 64'(scale_cnt), 64'd1);
    lit("peak_value", 64'(peak_value), 64'd200);
    lit("peak_index", 64'(peak_index), 64'd7);
    lit("peak_pulses", 64'(pv_count), 64'd1);

    for (int b = 0; b <= DEPTH; b++) val[b] = int'($urandom_range(511));
    val[0] = 77; val[DEPTH] = 5;
    run_round("r5", 0, 0, 7, DEPTH+1, 15, -1, 1, -1, 0, 20);
    lit("overrun", 64'(overrun), 64'd1);
    lit("r5_shift", 64'(noncoh_shift), 64'd7);

    for (int b = 0; b < DEPTH; b++) val[b] = int'($urandom_range(511));
    drive_cycle(0, 0, 0, 1, 0, 0, 2, 1);
    for (int b = 0; b < 30; b++) begin
      drive_cycle(1, val[b], 0, 0, 0, 0, 0, 1);
      if (b == 0) begin
        probe_at = cyc + 2; probe_exp = 77;
      end
    end
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    lit("midrst_lo", {noncoh_data, noncoh_shift, extra_shift, scale_cnt, busy, overrun, peak_valid}, 64'd0);
    lit("midrst_hi", {peak_value, peak_index}, 64'd0);
    $display("round r6: aborted by reset after 30 bins");
    idle(0);
    idle(1);

    for (int b = 0; b < DEPTH; b++) val[b] = int'($urandom_range(511));
    run_round("r7", 1, 1, 5, DEPTH, 10, -1, 1, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/noncoh_acc_ctrl.md
Name: noncoh_acc_ctrl

Overview:
- Accumulation controller on the other side of the noncoherent summation stage in the acquire engine.
- Per coherent result it owns the noncoherent accumulation buffer:
  - reads the stored value and presents it two cycles after coh_valid;
  - takes back the 9-bit summed result and its exceed flag;
  - writes the saturated value back.
- Manages per-round extra_shift scaling.
- On the last round, tracks the peak bin and reports it.

Parameters:
DEPTH, 64, number of bins per round (must be >= 4)
AW, 6, address width, ceil(log2(DEPTH))

Ports:
clk  in  1  system clock
rst_b  in  1  reset, asynchronous, active-low
round_start  in  1  pulse: begin a round; bin counter cleared
first_round  in  1  sampled with round_start: stored data treated as zero this round
last_round  in  1  sampled with round_start: enable peak search this round
noncoh_shift_cfg  in  4  shift applied to stored data, sampled with round_start
coh_valid  in  1  one coherent result this cycle (same strobe as the summation stage)
noncoh_out  in  9  summed result from the summation stage
exceed  in  1  exceed from the summation stage, one cycle before noncoh_out is latched
noncoh_data  out  8  stored accumulation for the bin, 2 cycles after coh_valid
noncoh_shift  out  4  shift for noncoh_data, constant within a round
extra_shift  out  1  halve sum this round
scale_cnt  out  4  number of extra_shift rounds so far (saturates at 15)
busy  out  1  round active or write-back pipeline non-empty
overrun  out  1  sticky: coh_valid beyond DEPTH bins in a round
peak_valid  out  1  one-cycle pulse when last-round peak is final
peak_value  out  9  largest noncoh_out of last round
peak_index  out  AW  bin of peak_value

Behaviour:
- Reset values:
  - all outputs 0;
  - internal exceed_seen 0;
  - bin counter 0;
  - pipeline valids 0.
  - Memory contents undefined; first_round covers this.
- Memory: DEPTH x 8, one synchronous read port and one write port, internal.
- round_start is accepted only when busy=0; when busy=1 it is ignored (no state change).
- On an accepted round_start:
  - latch first_round, last_round, noncoh_shift_cfg;
  - extra_shift <= exceed_seen, then exceed_seen <= 0;
  - if extra_shift is set this round, scale_cnt += 1 (saturating);
  - bin <= 0; set round_active.
- Pipeline for coh_valid at cycle t, bin b (b < DEPTH):
  - t: issue memory read at b; bin increments.
  - t+1: read data returns.
  - t+2: noncoh_data = first_round ? 0 : mem[b]. noncoh_data holds its value otherwise. Sample exceed: if 1, set exceed_seen.
  - t+3: noncoh_out valid. Write mem[b] <= noncoh_out[8] ? 8'd255 : noncoh_out[7:0]. If last_round, run the peak compare.
- noncoh_shift = latched noncoh_shift_cfg for the whole round.
- Round end: when bin reaches DEPTH, round_active <= 0. busy stays 1 until the t+3 stage of bin DEPTH-1 has completed.
- coh_valid while bin == DEPTH or round inactive:
  - set overrun (cleared only by reset);
  - no read, no write, no pipeline entry.
- Back-to-back coh_valid at full rate is supported. Addresses within a round are distinct, so there is no read/write hazard.
- Peak compare: a strictly greater noncoh_out replaces peak_value and peak_index, so ties keep the lowest index. Peak registers are cleared at round_start when last_round=1.
- peak_valid pulses one cycle after the final write-back of a last round.
- rst_b asserted mid-round: everything returns to reset values immediately; the in-flight write is dropped.

Test Plan:
- DEPTH=64, first_round=1, 64 back-to-back coh_valid -> noncoh_data=0 at t+2 for every bin; memory holds noncoh_out[7:0]; busy falls 3 cycles after the last coh_valid.
- Second round, first_round=0, noncoh_shift_cfg=3 -> noncoh_data for bin b equals the value written in round 1, exactly 2 cycles after its coh_valid; noncoh_shift=3 throughout.
- exceed=1 on bin 10 only in round 2 -> round 3 extra_shift=1, scale_cnt=1; round 4 extra_shift=0 if round 3 had no exceed.
- noncoh_out=9'h1FE written back -> stored 255, read as 255 next round.
- last_round with noncoh_out 100 at bin 5, 200 at bins 7 and 40 -> peak_value=200, peak_index=7, one peak_valid pulse.
- 65 coh_valid in a round, plus round_start while busy=1 -> overrun=1, memory unchanged at bin 0, the second round_start is ignored; assert rst_b mid-round -> all outputs 0.
